// File: rtl/fs_sched_pkg.sv
// Shared types and constants for the reassembly queue scheduler.
package fs_sched_pkg;

    localparam int unsigned QUEUE_NUM      = 32;
    localparam int unsigned QID_W          = 5;
    localparam int unsigned PKT_CNT_W      = 16;
    localparam int unsigned TMO_W          = 12;
    localparam int unsigned TIMEOUT_CYCLES = 4095;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_DONE = 2'd2,
        FREE      = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit at or above iv_ptr, wrapping.
module rr_priority_pick
    import fs_sched_pkg::*;
(
    input  logic [QUEUE_NUM-1:0] iv_eligible,
    input  logic [QID_W-1:0]     iv_ptr,
    output logic [QID_W-1:0]     ov_pick_id,
    output logic                 o_any
);

    logic [QUEUE_NUM-1:0] rot;
    logic [QID_W-1:0]     off;

    // Rotate so iv_ptr lands at bit 0, then find the lowest set bit.
    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < QUEUE_NUM; i++) begin
            rot[i] = iv_eligible[QID_W'(i) + iv_ptr];
        end
        for (int i = 0; i < QUEUE_NUM; i++) begin
            if (rot[QUEUE_NUM-1-i]) begin
                off = QID_W'(QUEUE_NUM-1-i);
            end
        end
    end

    assign ov_pick_id = off + iv_ptr;
    assign o_any      = |iv_eligible;

endmodule

// File: rtl/reassembly_queue_scheduler.sv
// Round-robin grant/free sequencer for the reassembly queues; one packet in flight.
// Optional watchdog abort enabled by defining QUEUE_SCHED_TIMEOUT_EN.
module reassembly_queue_scheduler
    import fs_sched_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [QUEUE_NUM-1:0] iv_queue_empty,
    input  logic [QUEUE_NUM-1:0] iv_queue_complete,
    input  logic                 i_sched_en,
    output logic [QID_W-1:0]     ov_queue_id,
    output logic                 o_queue_id_valid,
    input  logic                 i_queue_id_ack,
    input  logic                 i_pkt_done,
    output logic [QID_W-1:0]     ov_queue_id_free,
    output logic                 o_queue_id_free_wr,
    output logic [PKT_CNT_W-1:0] ov_pkt_cnt,
    output logic                 o_timeout,
    output logic                 o_busy
);

    sched_state_e         state_q,   state_d;
    logic [QID_W-1:0]     ptr_q,     ptr_d;
    logic [QID_W-1:0]     qid_q,     qid_d;
    logic                 valid_q,   valid_d;
    logic [QID_W-1:0]     free_id_q, free_id_d;
    logic                 free_wr_q, free_wr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 busy_q,    busy_d;

    logic [QUEUE_NUM-1:0] eligible;
    logic [QID_W-1:0]     pick_id;
    logic                 pick_any;
    logic                 done_ok;
    logic                 rel_go;

`ifdef QUEUE_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    assign eligible = ~iv_queue_empty & iv_queue_complete;

    rr_priority_pick u_pick (
        .iv_eligible (eligible),
        .iv_ptr      (ptr_q),
        .ov_pick_id  (pick_id),
        .o_any       (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        qid_d     = qid_q;
        valid_d   = valid_q;
        free_id_d = free_id_q;
        free_wr_d = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        done_ok   = 1'b0;
        rel_go    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_sched_en && pick_any) begin
                    qid_d   = pick_id;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (i_queue_id_ack) begin
                    valid_d = 1'b0;
                    done_ok = i_pkt_done;
                    state_d = i_pkt_done ? FREE : WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                done_ok = i_pkt_done;
                if (i_pkt_done) begin
                    state_d = FREE;
                end
            end
            FREE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rel_go = done_ok;

`ifdef QUEUE_SCHED_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE && state_d == GRANT) begin
            tmo_cnt_d = '0;
        end else if (state_q == GRANT || state_q == WAIT_DONE) begin
            // A completion landing on the limit cycle takes priority over the abort.
            if (!done_ok && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES)) begin
                timeout_d = 1'b1;
                valid_d   = 1'b0;
                state_d   = FREE;
                rel_go    = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif

        if (rel_go) begin
            free_wr_d = 1'b1;
            free_id_d = qid_q;
            ptr_d     = qid_q + QID_W'(1);
            if (done_ok) begin
                pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            qid_q     <= '0;
            valid_q   <= 1'b0;
            free_id_q <= '0;
            free_wr_q <= 1'b0;
            pkt_cnt_q <= '0;
            busy_q    <= 1'b0;
`ifdef QUEUE_SCHED_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            qid_q     <= qid_d;
            valid_q   <= valid_d;
            free_id_q <= free_id_d;
            free_wr_q <= free_wr_d;
            pkt_cnt_q <= pkt_cnt_d;
            busy_q    <= busy_d;
`ifdef QUEUE_SCHED_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign ov_queue_id        = qid_q;
    assign o_queue_id_valid   = valid_q;
    assign ov_queue_id_free   = free_id_q;
    assign o_queue_id_free_wr = free_wr_q;
    assign ov_pkt_cnt         = pkt_cnt_q;
    assign o_busy             = busy_q;

`ifdef QUEUE_SCHED_TIMEOUT_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule
